// File: rtl/rect_plot_scheduler.sv
// Round-robin arbiter that rasterizes one requester's rectangle at a time onto the
// shared vga_adapter plot port, one pixel per clock in row-major order.
module rect_plot_scheduler #(
  parameter int NREQ     = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] rx0,
  input  logic [NREQ*7-1:0] ry0,
  input  logic [NREQ*5-1:0] rw,
  input  logic [NREQ*4-1:0] rh,
  input  logic [NREQ*3-1:0] rcolour,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [8:0] SW = 9'(SCREEN_W);
  localparam logic [7:0] SH = 8'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  logic [7:0] rx0_arr [NREQ];
  logic [6:0] ry0_arr [NREQ];
  logic [4:0] rw_arr  [NREQ];
  logic [3:0] rh_arr  [NREQ];
  logic [2:0] rcol_arr[NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign rx0_arr[gi]  = rx0[8*gi +: 8];
      assign ry0_arr[gi]  = ry0[7*gi +: 7];
      assign rw_arr[gi]   = rw[5*gi +: 5];
      assign rh_arr[gi]   = rh[4*gi +: 4];
      assign rcol_arr[gi] = rcolour[3*gi +: 3];
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]   winner_reg, winner_next;
  logic [7:0]      x0_reg, x0_next;
  logic [6:0]      y0_reg, y0_next;
  logic [4:0]      w_reg, w_next;
  logic [3:0]      h_reg, h_next;
  logic [2:0]      col_reg, col_next;
  logic [4:0]      cx_reg, cx_next;
  logic [3:0]      cy_reg, cy_next;
  logic [7:0]      x_reg, x_next;
  logic [6:0]      y_reg, y_next;
  logic [2:0]      colour_reg, colour_next;
  logic            plot_reg, plot_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic            busy_reg, busy_next;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     rr_after;
  logic              last_pix;
  logic              draw_pix;
  logic [8:0]        px_next;
  logic [7:0]        py_next;

  // Rotate requests so bit 0 is the requester at rr_ptr; lowest set bit wins.
  assign req_dbl = {req, req};
  assign req_rot = NREQ'(req_dbl >> rr_ptr_reg);

  always_comb begin
    int pos;
    grant_valid = 1'b0;
    pos         = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_valid = 1'b1;
        pos         = int'(rr_ptr_reg) + k;
      end
    end
    if (pos >= NREQ) pos = pos - NREQ;
    grant_idx = IW'(pos);
  end

  always_comb begin
    int nxt;
    nxt = int'(grant_idx) + 1;
    if (nxt >= NREQ) nxt = 0;
    rr_after = IW'(nxt);
  end

  assign last_pix = (cx_reg == w_reg - 5'd1) && (cy_reg == h_reg - 4'd1);

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    winner_next = winner_reg;
    x0_next     = x0_reg;
    y0_next     = y0_reg;
    w_next      = w_reg;
    h_next      = h_reg;
    col_next    = col_reg;
    cx_next     = cx_reg;
    cy_next     = cy_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    colour_next = colour_reg;
    plot_next   = 1'b0;
    ack_next    = '0;
    done_next   = '0;
    draw_pix    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          winner_next = grant_idx;
          x0_next     = rx0_arr[grant_idx];
          y0_next     = ry0_arr[grant_idx];
          w_next      = rw_arr[grant_idx];
          h_next      = rh_arr[grant_idx];
          col_next    = rcol_arr[grant_idx];
          ack_next    = NREQ'(1) << grant_idx;
          rr_ptr_next = rr_after;
          cx_next     = '0;
          cy_next     = '0;
          if (rw_arr[grant_idx] == 5'd0 || rh_arr[grant_idx] == 4'd0) begin
            state_next = DONE;
          end else begin
            state_next = DRAW;
            draw_pix   = 1'b1;
          end
        end
      end
      DRAW: begin
        if (last_pix) begin
          state_next = DONE;
          done_next  = NREQ'(1) << winner_reg;
        end else begin
          if (cx_reg == w_reg - 5'd1) begin
            cx_next = '0;
            cy_next = cy_reg + 4'd1;
          end else begin
            cx_next = cx_reg + 5'd1;
          end
          draw_pix = 1'b1;
        end
      end
      DONE: begin
        // A zero-area rectangle enters DONE together with ack, so its done pulse
        // is issued one cycle later to keep ack and done on separate cycles.
        if (|done_reg) begin
          state_next = IDLE;
        end else begin
          done_next = NREQ'(1) << winner_reg;
        end
      end
      default: state_next = IDLE;
    endcase

    px_next = {1'b0, x0_next} + {4'b0, cx_next};
    py_next = {1'b0, y0_next} + {4'b0, cy_next};
    if (draw_pix) begin
      x_next      = px_next[7:0];
      y_next      = py_next[6:0];
      colour_next = col_next;
      plot_next   = (px_next < SW) && (py_next < SH);
    end
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      winner_reg <= '0;
      x0_reg     <= '0;
      y0_reg     <= '0;
      w_reg      <= '0;
      h_reg      <= '0;
      col_reg    <= '0;
      cx_reg     <= '0;
      cy_reg     <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
      plot_reg   <= 1'b0;
      ack_reg    <= '0;
      done_reg   <= '0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      winner_reg <= winner_next;
      x0_reg     <= x0_next;
      y0_reg     <= y0_next;
      w_reg      <= w_next;
      h_reg      <= h_next;
      col_reg    <= col_next;
      cx_reg     <= cx_next;
      cy_reg     <= cy_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      colour_reg <= colour_next;
      plot_reg   <= plot_next;
      ack_reg    <= ack_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
    end
  end

  assign ack    = ack_reg;
  assign done   = done_reg;
  assign busy   = busy_reg;
  assign x      = x_reg;
  assign y      = y_reg;
  assign colour = colour_reg;
  assign plot   = plot_reg;

endmodule

// File: tb/tb_rect_plot_scheduler.sv
// Scoreboard bench for rect_plot_scheduler: expected ack/pixel/done events with
// their cycle stamps are queued as stimulus is applied and popped as the DUT emits them.
`timescale 1ns/1ps
module tb_rect_plot_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] rx0;
  logic [20:0] ry0;
  logic [14:0] rw;
  logic [11:0] rh;
  logic [8:0]  rcolour;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  rect_plot_scheduler #(.NREQ(3), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .reset(reset), .req(req), .rx0(rx0), .ry0(ry0), .rw(rw), .rh(rh),
    .rcolour(rcolour), .ack(ack), .done(done), .busy(busy), .x(x), .y(y),
    .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;  // 0 ack, 1 pixel, 2 done
    int idx;
    int px;
    int py;
    int col;
    int at;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue the events one rectangle should produce when granted at cycle start.
  // cut >= 0 queues only the first cut pixel cycles and no done.
  function automatic int push_rect(input int idx, input int x0, input int y0, input int w,
                                   input int h, input int c, input int start, input int cut);
    ev_t r;
    int n;
    r = '{0, idx, 0, 0, 0, start};
    exp_q.push_back(r);
    if (w == 0 || h == 0) begin
      if (cut < 0) begin
        r = '{2, idx, 0, 0, 0, start + 1};
        exp_q.push_back(r);
      end
      return start + 1;
    end
    n = (cut < 0) ? w * h : cut;
    for (int k = 0; k < n; k++) begin
      if (x0 + k % w < 160 && y0 + k / w < 120) begin
        r = '{1, idx, x0 + k % w, y0 + k / w, c, start + k};
        exp_q.push_back(r);
      end
    end
    if (cut < 0) begin
      r = '{2, idx, 0, 0, 0, start + w * h};
      exp_q.push_back(r);
    end
    return start + w * h;
  endfunction

  task automatic observe(input int kind, input string tag, input int vec);
    ev_t r;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 1, 0);
      return;
    end
    r = exp_q.pop_front();
    check({tag, "_kind"}, kind, r.kind);
    check({tag, "_cycle"}, cyc, r.at);
    if (kind == 1) begin
      check("pix_x", x, r.px);
      check("pix_y", y, r.py);
      check("pix_colour", colour, r.col);
    end else begin
      check({tag, "_vec"}, vec, 1 << r.idx);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ack != 3'b000) observe(0, "ack", int'(ack));
      if (plot) observe(1, "pix", 0);
      if (done != 3'b000) observe(2, "done", int'(done));
    end
  end

  task automatic set_ops(input int i, input int x0, input int y0, input int w, input int h,
                         input int c);
    rx0[8*i +: 8]     = 8'(x0);
    ry0[7*i +: 7]     = 7'(y0);
    rw[5*i +: 5]      = 5'(w);
    rh[4*i +: 4]      = 4'(h);
    rcolour[3*i +: 3] = 3'(c);
  endtask

  task automatic goto(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s, d, s0, s1, s2, s3, s4, d0, d1, d2, d3, d4;
    reset = 1'b1; req = '0; rx0 = '0; ry0 = '0; rw = '0; rh = '0; rcolour = '0;
    repeat (3) @(negedge clk);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_plot", plot, 0);
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);

    // 1: basic 2x2 right after reset
    t = cyc;
    reset = 1'b0;
    set_ops(0, 10, 20, 2, 2, 4);
    req = 3'b001;
    d = push_rect(0, 10, 20, 2, 2, 4, t + 1, -1);
    check("t1_done_at", d, t + 5);
    for (int k = 1; k <= 7; k++) begin
      goto(t + k);
      if (k == 1) req = 3'b000;
      check("t1_busy", busy, (k <= 5) ? 1 : 0);
    end
    check("t1_hold_x", x, 11);
    check("t1_hold_y", y, 21);
    check("t1_hold_colour", colour, 4);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: clipping at the bottom-right corner
    t = cyc;
    set_ops(0, 158, 119, 4, 2, 3);
    req = 3'b001;
    d = push_rect(0, 158, 119, 4, 2, 3, t + 1, -1);
    goto(t + 1);
    req = 3'b000;
    goto(d + 1);
    check("t2_q_empty", exp_q.size(), 0);

    // 3: round robin with all three requesting, then 101
    reset = 1'b1;
    @(negedge clk);
    t = cyc;
    reset = 1'b0;
    set_ops(0, 20, 30, 2, 1, 1);
    set_ops(1, 40, 50, 1, 2, 2);
    set_ops(2, 60, 70, 1, 1, 5);
    req = 3'b111;
    s0 = t + 1;
    d0 = push_rect(0, 20, 30, 2, 1, 1, s0, -1);
    s1 = d0 + 2;
    d1 = push_rect(1, 40, 50, 1, 2, 2, s1, -1);
    s2 = d1 + 2;
    d2 = push_rect(2, 60, 70, 1, 1, 5, s2, -1);
    s3 = d2 + 2;
    d3 = push_rect(0, 5, 6, 1, 1, 7, s3, -1);
    s4 = d3 + 2;
    d4 = push_rect(2, 7, 8, 2, 1, 6, s4, -1);
    goto(s0); req[0] = 1'b0;
    goto(s1); req[1] = 1'b0;
    goto(s2);
    set_ops(0, 5, 6, 1, 1, 7);
    set_ops(2, 7, 8, 2, 1, 6);
    req = 3'b101;
    goto(s3); req[0] = 1'b0;
    goto(s4); req = 3'b000;
    goto(d4 + 1);
    check("t3_q_empty", exp_q.size(), 0);

    // 4: zero-area rectangles
    t = cyc;
    set_ops(0, 30, 40, 0, 5, 2);
    req = 3'b001;
    d = push_rect(0, 30, 40, 0, 5, 2, t + 1, -1);
    goto(t + 1); req = 3'b000;
    goto(d + 2);
    t = cyc;
    set_ops(2, 30, 40, 3, 0, 2);
    req = 3'b100;
    d = push_rect(2, 30, 40, 3, 0, 2, t + 1, -1);
    goto(t + 1); req = 3'b000;
    goto(d + 2);
    check("t4_q_empty", exp_q.size(), 0);

    // 5: reset during pixel 3 of a 4x4, then a fresh request
    t = cyc;
    set_ops(1, 50, 60, 4, 4, 3);
    req = 3'b010;
    s = t + 1;
    void'(push_rect(1, 50, 60, 4, 4, 3, s, 4));
    goto(s); req = 3'b000;
    goto(s + 3);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_plot", plot, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_x", x, 0);
    check("t5_rst_y", y, 0);
    check("t5_q_drained", exp_q.size(), 0);
    goto(s + 5);
    reset = 1'b0;
    set_ops(1, 70, 80, 2, 2, 1);
    req = 3'b010;
    s2 = s + 6;
    d = push_rect(1, 70, 80, 2, 2, 1, s2, -1);
    goto(s2); req = 3'b000;
    goto(d + 2);
    check("t5_q_empty", exp_q.size(), 0);

    // 6: one requester held high with a 1x1 rectangle
    t = cyc;
    set_ops(1, 100, 100, 1, 1, 5);
    req = 3'b010;
    s = t + 1;
    for (int n = 0; n < 4; n++) void'(push_rect(1, 100, 100, 1, 1, 5, s + 3 * n, -1));
    goto(s + 9); req = 3'b000;
    goto(s + 12);
    check("t6_busy_idle", busy, 0);
    check("t6_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
